// File: rtl/fetch_debug_pkg.sv
// Shared types and constants for the fetch-stage debug sequencer:
// FSM state encoding, command byte codes and the default HALT encoding.
package fetch_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_READY   = 3'd2,
    ST_RUN     = 3'd3,
    ST_STEP    = 3'd4,
    ST_DONE    = 3'd5,
    ST_RESTART = 3'd6
  } state_t;

  localparam logic [7:0] CMD_LOAD    = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP    = 8'h53;  // 'S'
  localparam logic [7:0] CMD_PAUSE   = 8'h50;  // 'P'
  localparam logic [7:0] CMD_RESTART = 8'h52;  // 'R'

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_debug_controller_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; o_word_valid pulses
// for one cycle after the 4th byte of each word.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_word_valid;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 2'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= 2'd0;
      end else if (i_valid) begin
        r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
        r_cnt                        <= r_cnt + 2'd1;
        r_word_valid                 <= (r_cnt == 2'd3);
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/fetch_debug_controller.sv
// Fetch-stage sequencer: loads a program from a byte stream, then runs or
// single-steps the PC until HALT. Optional cycle counter: STEP_CYCLE_CNT_EN.
module fetch_debug_controller
  import fetch_debug_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_halt_fetched,
  output logic              o_imem_wr_en,
  output logic [ADDR_W-1:0] o_imem_wr_addr,
  output logic [31:0]       o_imem_wr_data,
  output logic              o_PC_write,
  output logic              o_pipe_rst,
  output logic              o_halted,
  output logic              o_load_err,
  output logic [31:0]       o_cycle_count
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_load_err;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic              w_enter_load;
  logic              w_enter_restart;
  logic              w_last_addr;
  logic              w_is_halt;

  assign w_last_addr = (r_addr == {ADDR_W{1'b1}});
  assign w_is_halt   = (w_word == HALT_WORD);

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_enter_load),
    .i_byte       (i_rx_data),
    .i_valid      (i_rx_valid && (r_state == ST_LOAD)),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    o_pipe_rst   = 1'b0;
    o_PC_write   = 1'b0;
    o_halted     = 1'b0;
    o_imem_wr_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_pipe_rst = 1'b1;
        if (i_rx_valid && i_rx_data == CMD_LOAD) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_pipe_rst   = 1'b1;
        o_imem_wr_en = w_word_valid;
        if (w_word_valid && (w_is_halt || w_last_addr)) w_next = ST_READY;
      end
      ST_READY: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_CONT:    w_next = ST_RUN;
            CMD_STEP:    w_next = ST_STEP;
            CMD_LOAD:    w_next = ST_LOAD;
            CMD_RESTART: w_next = ST_RESTART;
            default:     w_next = ST_READY;
          endcase
        end
      end
      ST_RUN: begin
        o_PC_write = 1'b1;
        // Halt wins over a simultaneous pause.
        if (i_halt_fetched)                            w_next = ST_DONE;
        else if (i_rx_valid && i_rx_data == CMD_PAUSE) w_next = ST_READY;
      end
      ST_STEP: begin
        o_PC_write = 1'b1;
        w_next     = i_halt_fetched ? ST_DONE : ST_READY;
      end
      ST_DONE: begin
        o_halted = 1'b1;
        if (i_rx_valid && i_rx_data == CMD_RESTART)   w_next = ST_RESTART;
        else if (i_rx_valid && i_rx_data == CMD_LOAD) w_next = ST_LOAD;
      end
      ST_RESTART: begin
        o_pipe_rst = 1'b1;
        w_next     = ST_READY;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_load    = (w_next == ST_LOAD) && (r_state != ST_LOAD);
  assign w_enter_restart = (w_next == ST_RESTART) && (r_state != ST_RESTART);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_load) begin
        r_addr     <= '0;
        r_load_err <= 1'b0;
      end else if (o_imem_wr_en) begin
        // The address saturates at the top word instead of wrapping.
        if (!w_last_addr)             r_addr     <= r_addr + 1'b1;
        if (w_last_addr && !w_is_halt) r_load_err <= 1'b1;
      end
    end
  end

  assign o_imem_wr_addr = r_addr;
  assign o_imem_wr_data = w_word;
  assign o_load_err     = r_load_err;

`ifdef STEP_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (rst)                                r_cycle_count <= 32'd0;
    else if (w_enter_load || w_enter_restart) r_cycle_count <= 32'd0;
    else if (o_PC_write)                    r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Self-checking bench for fetch_debug_controller (ADDR_W=2, 4-word memory);
// expected writes, flags and cycle counts come from a behavioural model.
module tb_fetch_debug_controller;
  import fetch_debug_pkg::*;

  localparam int          ADDR_W = 2;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              i_halt_fetched;
  logic              o_imem_wr_en;
  logic [ADDR_W-1:0] o_imem_wr_addr;
  logic [31:0]       o_imem_wr_data;
  logic              o_PC_write;
  logic              o_pipe_rst;
  logic              o_halted;
  logic              o_load_err;
  logic [31:0]       o_cycle_count;

  int          total = 0;
  int          bad   = 0;
  int          pc_pulses = 0;
  int          exp_cycles = 0;
  bit          exp_err;
  logic [31:0] prog[$];
  wr_t         got_wr[$];
  wr_t         exp_wr[$];

  fetch_debug_controller #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .i_halt_fetched (i_halt_fetched),
    .o_imem_wr_en   (o_imem_wr_en),
    .o_imem_wr_addr (o_imem_wr_addr),
    .o_imem_wr_data (o_imem_wr_data),
    .o_PC_write     (o_PC_write),
    .o_pipe_rst     (o_pipe_rst),
    .o_halted       (o_halted),
    .o_load_err     (o_load_err),
    .o_cycle_count  (o_cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_imem_wr_en) got_wr.push_back('{int'(o_imem_wr_addr), o_imem_wr_data});
    if (o_PC_write) pc_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

  function automatic logic [31:0] exp_count();
`ifdef STEP_CYCLE_CNT_EN
    return 32'(exp_cycles);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == HALT);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic check_count(input string name);
    total++;
    if (o_cycle_count !== exp_count()) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, o_cycle_count, exp_count());
    end
  endtask

  // Model: words are written in order until HALT or the last address;
  // filling memory without HALT flags a load error.
  task automatic load_prog(input string name);
    got_wr.delete();
    exp_wr.delete();
    exp_err = 1'b0;
    send(CMD_LOAD);
    exp_cycles = 0;
    total++;
    if (o_pipe_rst !== 1'b1 || o_PC_write !== 1'b0) begin
      bad++;
      $display("FAIL %s_in_load: got rst=%0b pcw=%0b want rst=1 pcw=0", name, o_pipe_rst, o_PC_write);
    end
    for (int i = 0; i < prog.size() && i < DEPTH; i++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(prog[i][8*b +: 8]);
      end
      exp_wr.push_back('{i, prog[i]});
      if (prog[i] == HALT) break;
      if (i == DEPTH - 1) begin
        exp_err = 1'b1;
        break;
      end
    end
    tick();
    total++;
    if (got_wr.size() != exp_wr.size()) begin
      bad++;
      $display("FAIL %s_wr_count: got %0d want %0d", name, got_wr.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        total++;
        if (got_wr[i].addr != exp_wr[i].addr || got_wr[i].data !== exp_wr[i].data) begin
          bad++;
          $display("FAIL %s_wr%0d: got %0d:%08h want %0d:%08h", name, i,
                   got_wr[i].addr, got_wr[i].data, exp_wr[i].addr, exp_wr[i].data);
        end
      end
    end
    total++;
    if (o_load_err !== exp_err || o_pipe_rst !== 1'b0 || o_PC_write !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready: got err=%0b rst=%0b pcw=%0b want err=%0b rst=0 pcw=0",
               name, o_load_err, o_pipe_rst, o_PC_write, exp_err);
    end
  endtask

  task automatic do_steps(input string name, input int n);
    int p0 = pc_pulses;
    for (int k = 0; k < n; k++) begin
      send(CMD_STEP);
      exp_cycles++;
      total++;
      if (o_PC_write !== 1'b1) begin
        bad++;
        $display("FAIL %s_pulse%0d: got pcw=%0b want 1", name, k, o_PC_write);
      end
      tick();
      total++;
      if (o_PC_write !== 1'b0 || o_pipe_rst !== 1'b0 || o_halted !== 1'b0) begin
        bad++;
        $display("FAIL %s_ready%0d: got pcw=%0b rst=%0b halted=%0b want 0 0 0",
                 name, k, o_PC_write, o_pipe_rst, o_halted);
      end
    end
    total++;
    if (pc_pulses - p0 != n) begin
      bad++;
      $display("FAIL %s_pulses: got %0d want %0d", name, pc_pulses - p0, n);
    end
    check_count({name, "_count"});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (o_imem_wr_en !== 1'b0 || o_imem_wr_addr !== '0 || o_imem_wr_data !== 32'd0 ||
        o_PC_write !== 1'b0 || o_pipe_rst !== 1'b1 || o_halted !== 1'b0 || o_load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got we=%0b a=%0d d=%08h pcw=%0b rst=%0b h=%0b err=%0b want 0 0 0 0 1 0 0",
               o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data, o_PC_write, o_pipe_rst, o_halted, o_load_err);
    end
    check_count("reset_count");
    rst = 1'b0;
    got_wr.delete();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] g;
      do g = 8'($urandom); while (g == CMD_LOAD);
      send(g);
    end
    tick();
    total++;
    if (got_wr.size() != 0 || o_pipe_rst !== 1'b1) begin
      bad++;
      $display("FAIL idle_garbage: got writes=%0d rst=%0b want 0 1", got_wr.size(), o_pipe_rst);
    end
  endtask

  task automatic test_load_basic();
    prog = '{32'h2001_0013, HALT};
    load_prog("load_basic");
  endtask

  task automatic test_step();
    do_steps("step", 3);
  endtask

  task automatic test_run(input int n);
    int p0;
    prog = '{rand_word(), HALT};
    load_prog("run_load");
    p0 = pc_pulses;
    send(CMD_CONT);
    for (int k = 1; k <= n; k++) begin
      if (k == n) i_halt_fetched = 1'b1;
      total++;
      if (o_PC_write !== 1'b1) begin
        bad++;
        $display("FAIL run_cycle%0d: got pcw=%0b want 1", k, o_PC_write);
      end
      tick();
    end
    i_halt_fetched = 1'b0;
    exp_cycles = n;
    total++;
    if (o_halted !== 1'b1 || o_PC_write !== 1'b0 || pc_pulses - p0 != n) begin
      bad++;
      $display("FAIL run_done: got halted=%0b pcw=%0b pulses=%0d want 1 0 %0d",
               o_halted, o_PC_write, pc_pulses - p0, n);
    end
    check_count("run_count");
  endtask

  task automatic test_pause_halt();
    prog = '{rand_word(), rand_word(), HALT};
    load_prog("ph_load");
    send(CMD_CONT);
    repeat (2) tick();
    send(CMD_PAUSE);
    exp_cycles += 3;
    total++;
    if (o_PC_write !== 1'b0 || o_halted !== 1'b0 || o_pipe_rst !== 1'b0) begin
      bad++;
      $display("FAIL pause_ready: got pcw=%0b h=%0b rst=%0b want 0 0 0", o_PC_write, o_halted, o_pipe_rst);
    end
    check_count("pause_count");
    send(CMD_CONT);
    tick();
    i_halt_fetched = 1'b1;
    send(CMD_PAUSE);
    i_halt_fetched = 1'b0;
    exp_cycles += 2;
    total++;
    if (o_halted !== 1'b1 || o_PC_write !== 1'b0) begin
      bad++;
      $display("FAIL halt_and_pause: got h=%0b pcw=%0b want 1 0", o_halted, o_PC_write);
    end
    send(CMD_CONT);
    send(CMD_STEP);
    send(CMD_PAUSE);
    total++;
    if (o_halted !== 1'b1 || o_PC_write !== 1'b0 || o_pipe_rst !== 1'b0) begin
      bad++;
      $display("FAIL done_ignores: got h=%0b pcw=%0b rst=%0b want 1 0 0", o_halted, o_PC_write, o_pipe_rst);
    end
    check_count("done_count");
    send(CMD_RESTART);
    exp_cycles = 0;
    total++;
    if (o_pipe_rst !== 1'b1 || o_halted !== 1'b0 || o_PC_write !== 1'b0) begin
      bad++;
      $display("FAIL restart_pulse: got rst=%0b h=%0b pcw=%0b want 1 0 0", o_pipe_rst, o_halted, o_PC_write);
    end
    check_count("restart_count");
    tick();
    total++;
    if (o_pipe_rst !== 1'b0 || o_halted !== 1'b0) begin
      bad++;
      $display("FAIL restart_ready: got rst=%0b h=%0b want 0 0", o_pipe_rst, o_halted);
    end
    do_steps("after_restart", 1);
  endtask

  task automatic test_fill();
    prog.delete();
    repeat (DEPTH + 1) prog.push_back(rand_word());
    load_prog("fill");
    repeat (4) send(8'h00);
    repeat (2) tick();
    total++;
    if (got_wr.size() != DEPTH || o_load_err !== 1'b1) begin
      bad++;
      $display("FAIL fill_no_extra: got writes=%0d err=%0b want %0d 1", got_wr.size(), o_load_err, DEPTH);
    end
  endtask

  task automatic test_reset_mid_load();
    send(CMD_LOAD);
    send(8'h11);
    send(8'h22);
    got_wr.delete();
    rst = 1'b1;
    tick();
    total++;
    if (o_imem_wr_en !== 1'b0 || o_pipe_rst !== 1'b1 || o_load_err !== 1'b0 || o_imem_wr_addr !== '0) begin
      bad++;
      $display("FAIL mid_load_rst: got we=%0b rst=%0b err=%0b a=%0d want 0 1 0 0",
               o_imem_wr_en, o_pipe_rst, o_load_err, o_imem_wr_addr);
    end
    rst = 1'b0;
    tick();
    total++;
    if (got_wr.size() != 0) begin
      bad++;
      $display("FAIL mid_load_nowrite: got writes=%0d want 0", got_wr.size());
    end
    prog = '{32'hDDCC_BBAA, HALT};
    load_prog("fresh_load");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, DEPTH);
      prog.delete();
      repeat (n - 1) prog.push_back(rand_word());
      if ($urandom_range(0, 2) != 0) prog.push_back(HALT);
      else while (prog.size() <= DEPTH) prog.push_back(rand_word());
      load_prog("rand_load");
      do_steps("rand_step", $urandom_range(1, 4));
    end
  endtask

  initial begin
    rst            = 1'b1;
    i_rx_data      = 8'h00;
    i_rx_valid     = 1'b0;
    i_halt_fetched = 1'b0;
    test_reset();
    test_load_basic();
    test_step();
    test_run(5);
    test_pause_halt();
    test_fill();
    test_reset_mid_load();
    test_random();
    test_run($urandom_range(1, 9));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_debug_controller.md
Name: fetch_debug_controller

Overview:
Sequencer for the instruction fetch stage.
- Assembles a program arriving as a byte stream into 32-bit words and writes it into instruction memory while the pipeline is held in reset.
- Then drives the fetch stage's PC write enable in continuous-run or single-step mode until the HALT instruction is fetched.
- Sits between the UART receiver and the Instruction_Fetch/instruction-memory pair.

Parameters:
ADDR_W, 8, instruction-memory word-address width (depth = 2**ADDR_W words)
HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates load and run

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_halt_fetched  in  1  fetch stage currently holds HALT_WORD
o_imem_wr_en  out  1  instruction-memory write strobe
o_imem_wr_addr  out  ADDR_W  word write address
o_imem_wr_data  out  32  assembled word
o_PC_write  out  1  PC update enable to fetch stage
o_pipe_rst  out  1  active-high pipeline reset/flush
o_halted  out  1  program reached HALT
o_load_err  out  1  sticky: memory filled without HALT_WORD
o_cycle_count  out  32  executed-cycle counter (see Optional Feature)

Behaviour:
- Reset values: state IDLE; o_imem_wr_en=0, o_imem_wr_addr=0, o_imem_wr_data=0, o_PC_write=0, o_pipe_rst=1, o_halted=0, o_load_err=0, o_cycle_count=0.
- Commands are single bytes: 'L'=8'h4C load, 'C'=8'h43 continuous, 'S'=8'h53 step, 'P'=8'h50 pause, 'R'=8'h52 restart. Bytes that are undefined in the current state are ignored.
- A command accepted in cycle N produces its state change and outputs in cycle N+1.
- IDLE:
  - o_pipe_rst=1.
  - 'L' -> LOAD; clears address, byte counter and o_load_err.
- LOAD:
  - o_pipe_rst=1, o_PC_write=0. Every valid byte is data; commands are not decoded.
  - Bytes are little-endian: the first byte is [7:0].
  - When the 4th byte arrives in cycle N, o_imem_wr_en=1 for exactly cycle N+1 with the current addr/data. The address increments after the write.
  - If the written word equals HALT_WORD -> READY.
  - If the written address equals 2**ADDR_W-1 and the word is not HALT_WORD -> READY, o_load_err=1. The address does not wrap.
- READY:
  - o_pipe_rst=0, o_PC_write=0.
  - 'C' -> RUN; 'S' -> STEP; 'L' -> LOAD; 'R' -> RESTART.
- RUN:
  - o_PC_write=1 every cycle.
  - i_halt_fetched=1 -> DONE, with o_PC_write=0 from the next cycle.
  - 'P' -> READY.
  - i_halt_fetched and 'P' in the same cycle -> DONE.
- STEP:
  - o_PC_write=1 for exactly one cycle, then -> READY.
  - If i_halt_fetched=1 during that cycle -> DONE instead.
  - Received bytes are ignored.
- DONE:
  - o_halted=1, o_PC_write=0.
  - 'R' -> RESTART; 'L' -> LOAD. 'C', 'S' and 'P' are ignored.
- RESTART:
  - One cycle with o_pipe_rst=1 (PC back to 0), o_halted=0, then -> READY.
- rst asserted in any state, including mid-word in LOAD: immediate return to reset values. The partial word is discarded and no write strobe is issued.
- i_rx_valid with garbage while in IDLE: ignored; no write occurs.

Optional Feature:
STEP_CYCLE_CNT_EN
- Defined: o_cycle_count increments by 1 in every cycle where o_PC_write=1. It is cleared on entering LOAD or RESTART, holds otherwise, and wraps modulo 2**32.
- Undefined: o_cycle_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package fetch_debug_pkg holds:
  - state encoding (IDLE, LOAD, READY, RUN, STEP, DONE, RESTART; 3-bit)
  - command byte constants CMD_LOAD/CMD_CONT/CMD_STEP/CMD_PAUSE/CMD_RESTART
  - HALT_WORD default
- One sub-module, word_assembler:
  - inputs: clk, rst, clear, byte, valid
  - outputs: 32-bit word, word_valid one-cycle strobe
  - contains the 2-bit byte counter
- The FSM, address counter and optional cycle counter stay in the top module.

Test Plan:
1. rst for 2 cycles, then 'L' followed by bytes 0x13,0x00,0x01,0x20 then FF,FF,FF,FF -> writes 32'h20010013 @0 and 32'hFFFFFFFF @1; state READY; o_pipe_rst drops to 0; o_load_err=0.
2. From READY send 'S' three times -> exactly three single-cycle o_PC_write pulses; state READY after each.
3. Load 2 words (second = HALT_WORD), send 'C', drive i_halt_fetched=1 at the 5th RUN cycle -> o_PC_write high for 5 cycles, then o_halted=1. With STEP_CYCLE_CNT_EN, o_cycle_count=5.
4. In RUN, send 'P' in the same cycle i_halt_fetched=1 -> DONE, o_halted=1. Then 'C' -> ignored. Then 'R' -> one-cycle o_pipe_rst, o_halted=0, READY.
5. ADDR_W=2: load 16 bytes with no HALT_WORD -> 4 writes at addr 0..3, o_load_err=1, state READY, no 5th write.
6. Assert rst after 2 data bytes in LOAD, then 'L' and 4 fresh bytes AA,BB,CC,DD -> single write 32'hDDCCBBAA @0; stale bytes not merged.
